// File: rtl/delay_reaction_timer.sv
// Reaction-time game: random pre-stimulus delay, then count ticks until the button is pressed.
// Optional best-score register is enabled with `define RT_BEST_SCORE_EN.
module delay_reaction_timer #(
    parameter int DELAY_BASE  = 1000,
    parameter int DELAY_SHIFT = 3,
    parameter int RT_MAX      = 9999
) (
    input  logic        clk,
    input  logic        res,
    input  logic        cenable,
    input  logic [7:0]  seed,
    input  logic        tick,
    input  logic        btn,
    output logic        led,
    output logic [13:0] rt,
    output logic        done,
    output logic        early,
    output logic        busy,
    output logic [13:0] best
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_GO,
        S_DONE,
        S_FOUL
    } state_t;

    localparam logic [13:0] RT_SAT = 14'(RT_MAX);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [13:0] rt_q, rt_d;
    logic        cen_prev_q, cen_prev_d;
    logic        btn_prev_q, btn_prev_d;
    logic        cen_edge;
    logic        btn_edge;
    logic [15:0] load_val;

    assign cen_edge   = cenable & ~cen_prev_q;
    assign btn_edge   = btn & ~btn_prev_q;
    assign cen_prev_d = cenable;
    assign btn_prev_d = btn;
    assign load_val   = 16'(DELAY_BASE) + (16'(seed) << DELAY_SHIFT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rt_d    = rt_q;
        case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
                if (cen_edge) begin
                    cnt_d   = load_val;
                    rt_d    = '0;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                // A false start beats a coincident tick; a zero load skips straight to GO.
                if (btn_edge) begin
                    state_d = S_FOUL;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_GO;
                end else if (tick) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_GO;
                    end
                end
            end
            S_GO: begin
                if (btn_edge) begin
                    state_d = S_DONE;
                end else if (tick && (rt_q < RT_SAT)) begin
                    rt_d = rt_q + 14'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rt_q       <= '0;
            cen_prev_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rt_q       <= rt_d;
            cen_prev_q <= cen_prev_d;
            btn_prev_q <= btn_prev_d;
        end
    end

`ifdef RT_BEST_SCORE_EN
    logic [13:0] best_q, best_d;

    // rt is frozen on the GO->DONE transition, so rt_q is the final score here.
    always_comb begin
        best_d = best_q;
        if ((state_q == S_GO) && (state_d == S_DONE) &&
            ((best_q == 14'd0) || (rt_q < best_q))) begin
            best_d = rt_q;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best = best_q;
`else
    assign best = '0;
`endif

    assign led   = (state_q == S_GO);
    assign done  = (state_q == S_DONE);
    assign early = (state_q == S_FOUL);
    assign busy  = (state_q == S_DELAY) || (state_q == S_GO);
    assign rt    = rt_q;

endmodule

// File: tb/tb_delay_reaction_timer.sv
// Bench for delay_reaction_timer: directed scenarios plus randomized trials checked against a tick-count model.
`timescale 1ns/1ps
module tb_delay_reaction_timer;

    localparam int TB_BASE  = 10;
    localparam int TB_SHIFT = 0;
    localparam int TB_RTMAX = 9999;

    logic        clk = 1'b0;
    logic        res;
    logic        cenable;
    logic [7:0]  seed;
    logic        tick;
    logic        btn;
    logic        led, done, early, busy;
    logic [13:0] rt, best;
    logic        led0, done0, early0, busy0;
    logic [13:0] rt0, best0;

    int n_assert = 0;
    int n_fail   = 0;
    int best_m   = 0;

    always #5 clk = ~clk;

    delay_reaction_timer #(
        .DELAY_BASE(TB_BASE), .DELAY_SHIFT(TB_SHIFT), .RT_MAX(TB_RTMAX)
    ) dut (
        .clk(clk), .res(res), .cenable(cenable), .seed(seed), .tick(tick), .btn(btn),
        .led(led), .rt(rt), .done(done), .early(early), .busy(busy), .best(best)
    );

    delay_reaction_timer #(
        .DELAY_BASE(0), .DELAY_SHIFT(0), .RT_MAX(TB_RTMAX)
    ) dut0 (
        .clk(clk), .res(res), .cenable(cenable), .seed(seed), .tick(tick), .btn(btn),
        .led(led0), .rt(rt0), .done(done0), .early(early0), .busy(busy0), .best(best0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_best(input string tag);
`ifdef RT_BEST_SCORE_EN
        chk(tag, 32'(best), 32'(best_m));
`else
        chk(tag, 32'(best), 32'd0);
`endif
    endtask

    task automatic chk_outs(input string tag, input logic e_led, input logic e_done,
                            input logic e_early, input logic e_busy, input int e_rt);
        chk({tag, ".led"},   32'(led),   32'(e_led));
        chk({tag, ".done"},  32'(done),  32'(e_done));
        chk({tag, ".early"}, 32'(early), 32'(e_early));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
        chk({tag, ".rt"},    32'(rt),    32'(e_rt));
    endtask

    // Inputs change just after a falling edge; outputs are read at the next falling edge.
    task automatic cyc(input logic t);
        tick = t;
        @(negedge clk);
    endtask

    task automatic do_tick();
        cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic start_trial(input logic [7:0] s);
        seed    = s;
        cenable = 1'b1;
        cyc(1'b0);
    endtask

    task automatic end_trial();
        btn     = 1'b0;
        cenable = 1'b0;
        cyc(1'b0);
    endtask

    task automatic do_reset();
        res = 1'b0; cenable = 1'b0; btn = 1'b0; seed = 8'd0;
        cyc(1'b0); cyc(1'b0);
        best_m = 0;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("reset.best", 32'(best), 32'd0);
        chk("reset.busy0", 32'(busy0), 32'd0);
        res = 1'b1;
        cyc(1'b0);
    endtask

    // Model: the delay lasts D = base + (seed << shift) ticks; a press after p ticks
    // (counted from the start of the delay) fouls if p < D, else scores min(p - D, RT_MAX).
    task automatic run_trial(input logic [7:0] s, input int p, input logic held);
        int d;
        int k;
        int e_rt;
        d = TB_BASE + (int'(s) << TB_SHIFT);
        k = 0;
        if (held) begin
            btn = 1'b1;
            cyc(1'b0);
        end
        start_trial(s);
        chk("trial.busy_start", 32'(busy), 32'd1);
        if (held && p > 0) begin
            do_tick();
            k = 1;
        end
        btn = 1'b0;
        cyc(1'b0);
        do_ticks(p - k);
        chk("trial.led_before_press", 32'(led), 32'(p >= d));
        btn = 1'b1;
        cyc(1'b0);
        if (p < d) begin
            chk_outs("trial.foul", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        end else begin
            e_rt = (p - d > TB_RTMAX) ? TB_RTMAX : p - d;
            if (best_m == 0 || e_rt < best_m) best_m = e_rt;
            chk_outs("trial.done", 1'b0, 1'b1, 1'b0, 1'b0, e_rt);
        end
        chk_best("trial.best");
        end_trial();
    endtask

    initial begin
        res = 1'b0; cenable = 1'b0; seed = 8'd0; tick = 1'b0; btn = 1'b0;
        do_reset();

        // Basic trial with an ignored cenable re-trigger during the delay.
        start_trial(8'd5);
        chk_outs("go.start", 1'b0, 1'b0, 1'b0, 1'b1, 0);
        do_ticks(5);
        cenable = 1'b0; cyc(1'b0);
        seed = 8'd200; cenable = 1'b1; cyc(1'b0);
        do_ticks(9);
        chk_outs("go.tick14", 1'b0, 1'b0, 1'b0, 1'b1, 0);
        do_tick();
        chk_outs("go.tick15", 1'b1, 1'b0, 1'b0, 1'b1, 0);
        do_ticks(7);
        btn = 1'b1; cyc(1'b0);
        if (best_m == 0 || 7 < best_m) best_m = 7;
        chk_outs("go.press7", 1'b0, 1'b1, 1'b0, 1'b0, 7);
        chk_best("go.best");
        end_trial();

        // False start after the third delay tick.
        start_trial(8'd5);
        do_ticks(3);
        btn = 1'b1; cyc(1'b0);
        chk_outs("foul.press", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        btn = 1'b0;
        do_ticks(20);
        chk_outs("foul.hold", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk_best("foul.best");
        end_trial();

        // Press coincident with a tick at rt=4.
        start_trial(8'd5);
        do_ticks(19);
        chk_outs("same.rt4", 1'b1, 1'b0, 1'b0, 1'b1, 4);
        btn = 1'b1; cyc(1'b1);
        if (best_m == 0 || 4 < best_m) best_m = 4;
        chk_outs("same.done", 1'b0, 1'b1, 1'b0, 1'b0, 4);
        end_trial();

        // Saturation.
        start_trial(8'd5);
        do_ticks(15 + 10000);
        chk_outs("sat.go", 1'b1, 1'b0, 1'b0, 1'b1, TB_RTMAX);
        btn = 1'b1; cyc(1'b0);
        chk_outs("sat.done", 1'b0, 1'b1, 1'b0, 1'b0, TB_RTMAX);
        chk_best("sat.best");
        end_trial();

        // Best score: 20, 12, 15, then a foul.
        do_reset();
        run_trial(8'd0, 30, 1'b0);
        run_trial(8'd0, 22, 1'b0);
        run_trial(8'd0, 25, 1'b0);
        run_trial(8'd0, 3, 1'b0);
`ifdef RT_BEST_SCORE_EN
        chk("best.final", 32'(best), 32'd12);
`else
        chk("best.final", 32'(best), 32'd0);
`endif

        // Asynchronous reset in GO, then wait in IDLE.
        start_trial(8'd0);
        do_ticks(12);
        chk("areset.led_before", 32'(led), 32'd1);
        #2 res = 1'b0;
        #1;
        best_m = 0;
        chk_outs("areset.async", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("areset.best", 32'(best), 32'd0);
        cenable = 1'b0;
        @(negedge clk);
        res = 1'b1;
        cyc(1'b0);
        do_ticks(3);
        chk_outs("areset.idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Zero-length delay on the DELAY_BASE=0 instance.
        do_reset();
        start_trial(8'd0);
        chk("zero.busy", 32'(busy0), 32'd1);
        chk("zero.led1", 32'(led0), 32'd0);
        cyc(1'b0);
        chk("zero.led2", 32'(led0), 32'd1);
        end_trial();

        // Randomized trials, some with the button held across the start.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] s;
            logic       h;
            int         p;
            s = 8'($urandom_range(0, 63));
            h = 1'($urandom_range(0, 1));
            p = $urandom_range(0, TB_BASE + int'(s) + 30);
            run_trial(s, p, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_reaction_timer.md
DELAY_REACTION_TIMER -- requirements
Module: delay_reaction_timer

Interface
REQ-001 Parameter DELAY_BASE, default 1000: fixed part of the pre-stimulus delay, in ticks.
REQ-002 Parameter DELAY_SHIFT, default 3: left shift applied to the seed to form the random part of the delay.
REQ-003 Parameter RT_MAX, default 9999: saturation value of the reaction count.
REQ-004 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 Port res  in  1: reset, asynchronous, active-low.
REQ-006 Port cenable  in  1: seed-valid level from the random generator; its rising edge starts a trial.
REQ-007 Port seed  in  8: random value, sampled in the same cycle cenable rises.
REQ-008 Port tick  in  1: one-cycle time-base enable pulse, nominally 1 ms.
REQ-009 Port btn  in  1: player button level, already synchronised to clk.
REQ-010 Port led  out  1: stimulus lamp; high only in state GO.
REQ-011 Port rt  out  14: reaction time in ticks; valid while done=1.
REQ-012 Port done  out  1: high in state DONE.
REQ-013 Port early  out  1: high in state FOUL (false start).
REQ-014 Port busy  out  1: high in states DELAY and GO.
REQ-015 Port best  out  14: best (minimum) reaction time, see Configuration.

Function
REQ-016 Rising edges of cenable and btn are detected internally with one registered copy of each signal; an edge is input high with the previous sample low.
REQ-017 The FSM has states IDLE, DELAY, GO, DONE and FOUL.
REQ-018 In IDLE, DONE or FOUL, a cenable edge loads cnt = DELAY_BASE + (seed << DELAY_SHIFT), zero-extended to 16 bits, clears rt and enters DELAY on the next cycle.
REQ-019 In DELAY, each tick decrements cnt; the tick that takes cnt to 0 moves the FSM to GO on the next cycle.
REQ-020 If the loaded cnt is 0, DELAY lasts exactly one cycle and then moves to GO without waiting for a tick.
REQ-021 In DELAY, a btn edge moves the FSM to FOUL and takes priority over a tick in the same cycle.
REQ-022 In GO, each tick increments rt, which saturates at RT_MAX.
REQ-023 In GO, a btn edge moves the FSM to DONE; a tick in the same cycle is not counted.
REQ-024 rt holds its value in DONE and FOUL, and holds 0 in FOUL.
REQ-025 A btn held high across the start of a trial produces no edge and causes no foul.
REQ-026 A cenable edge received in DELAY or GO is ignored.
REQ-027 Outputs are decoded from registered state only, with no combinational path from an input to an output.

Reset
REQ-028 With res low, the FSM is in IDLE; cnt=0; rt=0; best=0; led, done, early and busy are 0; both edge-detect registers are 0.
REQ-029 Asserting reset mid-trial aborts the trial immediately; after release the block waits in IDLE for a fresh cenable edge.

Configuration
REQ-030 The feature is controlled by macro RT_BEST_SCORE_EN.
REQ-031 With RT_BEST_SCORE_EN defined, on each entry to DONE, best loads rt if best==0 or rt<best; FOUL never updates best; only reset clears best.
REQ-032 Without RT_BEST_SCORE_EN, best is tied to 0 and no comparator or register is built.

Verification (DELAY_BASE=10, DELAY_SHIFT=0, tick every 4th clk)
REQ-033 Reset, cenable rise with seed=5, btn low -> led rises after the 15th tick; busy is high from the cycle after the edge.
REQ-034 Same as REQ-033, then btn rises after the 7th tick in GO -> done=1, rt=7, led=0, busy=0.
REQ-035 seed=5, btn rises after the 3rd tick of DELAY -> early=1, rt=0, led never rises.
REQ-036 In GO, btn edge and tick arrive in the same cycle with rt=4 -> DONE with rt=4; separately, no btn for 10000 ticks -> rt=9999.
REQ-037 With RT_BEST_SCORE_EN defined, trials scoring 20, 12 and 15, then a foul -> best=12; res pulsed low mid-GO -> all outputs 0 asynchronously.
REQ-038 DELAY_BASE=0 with seed=0 -> led high two cycles after the cenable edge.
